vlan_tagger: RTL and testbench

VLAN_TAGGER -- requirements
Module: vlan_tagger

---
 rtl/vlan_tagger.sv | 184 ++++++++++++++++++
 tb/tb_vlan_tagger.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/vlan_tagger.sv
// Egress VLAN tagger: inserts an 802.1Q tag after the MAC addresses on trunk ports, filters access ports.
// Define VLAN_TAGGER_STATS_EN to add the tagged_count / dropped_count statistics outputs.
module vlan_tagger (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] port_vlan,
    input  logic        tag_enable,
    input  logic        native_untagged,
    input  logic        in_start,
    input  logic        in_data_valid,
    input  logic [2:0]  in_bytes_valid,
    input  logic [31:0] in_data,
    input  logic        in_commit,
    input  logic        in_drop,
    input  logic [11:0] in_frame_vlan,
    output logic        in_ready,
    output logic        out_start,
    output logic        out_data_valid,
    output logic [2:0]  out_bytes_valid,
    output logic [31:0] out_data,
    output logic        out_commit,
    output logic        out_drop
`ifdef VLAN_TAGGER_STATS_EN
    ,
    output logic [31:0] tagged_count,
    output logic [31:0] dropped_count
`endif
);

    typedef enum logic [2:0] {IDLE, HEADER, TAG, BODY, DISCARD} state_t;

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        long_q, long_d;
    logic        ins_q, ins_d;
    logic [11:0] vlan_q, vlan_d;
    logic        start_q, start_d;
    logic        dv_q, dv_d;
    logic [2:0]  bv_q, bv_d;
    logic [31:0] data_q, data_d;
    logic        commit_q, commit_d;
    logic        drop_q, drop_d;
    logic        acc_data, acc_commit, active, frame_open;

    assign in_ready   = (state_q != TAG);
    assign acc_data   = in_data_valid & in_ready;
    assign acc_commit = in_commit & in_ready;
    assign active     = (state_q != IDLE);
    assign frame_open = (state_q == HEADER) || (state_q == TAG) || (state_q == BODY);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        long_d   = long_q;
        ins_d    = ins_q;
        vlan_d   = vlan_q;
        start_d  = 1'b0;
        dv_d     = 1'b0;
        bv_d     = 3'd0;
        data_d   = data_q;
        commit_d = 1'b0;
        drop_d   = 1'b0;

        if (in_start) begin
            start_d = 1'b1;
            vlan_d  = in_frame_vlan;
            cnt_d   = 2'd0;
            long_d  = 1'b0;
            // An open previous frame is aborted alongside the new start.
            drop_d  = frame_open || (in_drop && active);
            if (!tag_enable && (in_frame_vlan != port_vlan)) begin
                state_d = DISCARD;
                ins_d   = 1'b0;
                drop_d  = 1'b1;
            end else begin
                state_d = HEADER;
                ins_d   = tag_enable && !(native_untagged && (in_frame_vlan == port_vlan));
            end
        end else if (in_drop && active) begin
            drop_d  = 1'b1;
            state_d = IDLE;
        end else begin
            case (state_q)
                HEADER: begin
                    if (acc_data) begin
                        dv_d   = 1'b1;
                        bv_d   = in_bytes_valid;
                        data_d = in_data;
                        cnt_d  = (cnt_q == 2'd3) ? cnt_q : cnt_q + 2'd1;
                        if (cnt_q == 2'd2) begin
                            if (in_bytes_valid < 3'd4) begin
                                dv_d    = 1'b0;
                                drop_d  = 1'b1;
                                state_d = DISCARD;
                            end else begin
                                state_d = ins_q ? TAG : BODY;
                            end
                        end
                    end
                    if (acc_commit) begin
                        drop_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
                TAG: begin
                    dv_d    = 1'b1;
                    bv_d    = 3'd4;
                    data_d  = {16'h8100, 3'b000, 1'b0, vlan_q};
                    state_d = BODY;
                end
                BODY: begin
                    if (acc_data) begin
                        dv_d   = 1'b1;
                        bv_d   = in_bytes_valid;
                        data_d = in_data;
                        long_d = 1'b1;
                        cnt_d  = (cnt_q == 2'd3) ? cnt_q : cnt_q + 2'd1;
                    end
                    // A commit before any word past the MAC header marks a runt.
                    if (acc_commit) begin
                        state_d  = IDLE;
                        commit_d = long_q || acc_data;
                        drop_d   = !(long_q || acc_data);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= 2'd0;
            long_q   <= 1'b0;
            ins_q    <= 1'b0;
            vlan_q   <= 12'd0;
            start_q  <= 1'b0;
            dv_q     <= 1'b0;
            bv_q     <= 3'd0;
            data_q   <= 32'd0;
            commit_q <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            long_q   <= long_d;
            ins_q    <= ins_d;
            vlan_q   <= vlan_d;
            start_q  <= start_d;
            dv_q     <= dv_d;
            bv_q     <= bv_d;
            data_q   <= data_d;
            commit_q <= commit_d;
            drop_q   <= drop_d;
        end
    end

    assign out_start       = start_q;
    assign out_data_valid  = dv_q;
    assign out_bytes_valid = bv_q;
    assign out_data        = data_q;
    assign out_commit      = commit_q;
    assign out_drop        = drop_q;

`ifdef VLAN_TAGGER_STATS_EN
    logic [31:0] tagged_q, dropped_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tagged_q  <= 32'd0;
            dropped_q <= 32'd0;
        end else begin
            if (commit_d && ins_q) tagged_q <= tagged_q + 32'd1;
            if (drop_d) dropped_q <= dropped_q + 32'd1;
        end
    end

    assign tagged_count  = tagged_q;
    assign dropped_count = dropped_q;
`endif

endmodule

// File: tb/tb_vlan_tagger.sv
// Directed, table-driven bench for vlan_tagger: one record per clock cycle, plus reset sequences.
module tb_vlan_tagger;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] port_vlan = 12'd0;
    logic        tag_enable = 1'b0;
    logic        native_untagged = 1'b0;
    logic        in_start = 1'b0;
    logic        in_data_valid = 1'b0;
    logic [2:0]  in_bytes_valid = 3'd0;
    logic [31:0] in_data = 32'd0;
    logic        in_commit = 1'b0;
    logic        in_drop = 1'b0;
    logic [11:0] in_frame_vlan = 12'd0;
    logic        in_ready;
    logic        out_start, out_data_valid, out_commit, out_drop;
    logic [2:0]  out_bytes_valid;
    logic [31:0] out_data;
`ifdef VLAN_TAGGER_STATS_EN
    logic [31:0] tagged_count, dropped_count;
`endif

    vlan_tagger dut (
        .clk(clk), .rst(rst), .port_vlan(port_vlan), .tag_enable(tag_enable),
        .native_untagged(native_untagged), .in_start(in_start),
        .in_data_valid(in_data_valid), .in_bytes_valid(in_bytes_valid),
        .in_data(in_data), .in_commit(in_commit), .in_drop(in_drop),
        .in_frame_vlan(in_frame_vlan), .in_ready(in_ready), .out_start(out_start),
        .out_data_valid(out_data_valid), .out_bytes_valid(out_bytes_valid),
        .out_data(out_data), .out_commit(out_commit), .out_drop(out_drop)
`ifdef VLAN_TAGGER_STATS_EN
        , .tagged_count(tagged_count), .dropped_count(dropped_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic        te, nu;
        logic [11:0] pv;
        logic        st, dv;
        logic [2:0]  bv;
        logic [31:0] d;
        logic        cm, dr;
        logic [11:0] fv;
        logic        rdy;
        logic        ost, odv;
        logic [2:0]  obv;
        logic [31:0] od;
        logic        ocm, odr;
    } vec_t;

    vec_t        tbl[$];
    int          total = 0;
    int          bad = 0;
    logic        cfg_te = 1'b0, cfg_nu = 1'b0;
    logic [11:0] cfg_pv = 12'd0;

    function automatic logic [31:0] W(int f, int i);
        return {8'hA5, 8'(f), 8'h3C, 8'(i)};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic push(input string nm, input logic st, input logic dv, input logic [2:0] bv,
                        input logic [31:0] d, input logic cm, input logic dr, input logic [11:0] fv,
                        input logic rdy, input logic ost, input logic odv, input logic [2:0] obv,
                        input logic [31:0] od, input logic ocm, input logic odr);
        vec_t v;
        v.nm = nm; v.te = cfg_te; v.nu = cfg_nu; v.pv = cfg_pv;
        v.st = st; v.dv = dv; v.bv = bv; v.d = d; v.cm = cm; v.dr = dr; v.fv = fv;
        v.rdy = rdy; v.ost = ost; v.odv = odv; v.obv = obv; v.od = od; v.ocm = ocm; v.odr = odr;
        tbl.push_back(v);
    endtask

    task automatic strt(input string nm, input logic [11:0] fv, input logic edrop);
        push(nm, 1, 0, 3'd0, 32'd0, 0, 0, fv, 1, 1, 0, 3'd0, 32'd0, 0, edrop);
    endtask

    task automatic fwd(input string nm, input logic [31:0] d, input logic cm);
        push(nm, 0, 1, 3'd4, d, cm, 0, 12'd0, 1, 0, 1, 3'd4, d, cm, 0);
    endtask

    task automatic stall(input string nm, input logic dv, input logic [31:0] d, input logic cm,
                         input logic [31:0] tagw);
        push(nm, 0, dv, 3'd4, d, cm, 0, 12'd0, 0, 0, 1, 3'd4, tagw, 0, 0);
    endtask

    task automatic idle(input string nm);
        push(nm, 0, 0, 3'd0, 32'd0, 0, 0, 12'd0, 1, 0, 0, 3'd0, 32'd0, 0, 0);
    endtask

    task automatic chk_quiet(input string nm);
        chk(nm, {in_ready, out_start, out_data_valid, out_bytes_valid, out_data, out_commit, out_drop},
            {1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 1'b0, 1'b0});
    endtask

    initial begin
        // Data and drop while idle are ignored.
        push("idle data", 0, 1, 3'd4, W(0, 0), 1, 0, 12'd0, 1, 0, 0, 3'd0, 32'd0, 0, 0);
        push("idle drop", 0, 0, 3'd0, 32'd0, 0, 1, 12'd0, 1, 0, 0, 3'd0, 32'd0, 0, 0);

        // Trunk, 16-word frame, VID 0x064.
        cfg_te = 1; cfg_nu = 0; cfg_pv = 12'd1;
        strt("s1 start", 12'h064, 0);
        for (int i = 0; i < 3; i++) fwd("s1 hdr", W(1, i), 0);
        stall("s1 tag", 1, W(1, 3), 0, 32'h8100_0064);
        for (int i = 3; i < 16; i++) fwd("s1 body", W(1, i), i == 15);
        idle("s1 after");

        // Native VLAN on trunk leaves untagged; 4-word frame is the shortest non-runt.
        cfg_te = 1; cfg_nu = 1; cfg_pv = 12'd5;
        strt("s2 start", 12'd5, 0);
        for (int i = 0; i < 4; i++) fwd("s2 word", W(2, i), i == 3);
        idle("s2 after");

        // Access port, foreign VLAN.
        cfg_te = 0; cfg_nu = 0; cfg_pv = 12'd5;
        strt("s3 start", 12'd7, 1);
        for (int i = 0; i < 4; i++)
            push("s3 suppressed", 0, 1, 3'd4, W(3, i), i == 3, 0, 12'd0, 1, 0, 0, 3'd0, 32'd0, 0, 0);
        idle("s3 after");

        // Access port, own VLAN, runt commit inside the header.
        strt("s8 start", 12'd5, 0);
        fwd("s8 w0", W(8, 0), 0);
        push("s8 runt", 0, 1, 3'd4, W(8, 1), 1, 0, 12'd0, 1, 0, 1, 3'd4, W(8, 1), 0, 1);
        idle("s8 after");

        // Tagged 12-byte frame: tag goes out, then runt drop.
        cfg_te = 1; cfg_nu = 0; cfg_pv = 12'd1;
        strt("s4 start", 12'h00A, 0);
        for (int i = 0; i < 3; i++) fwd("s4 hdr", W(4, i), 0);
        stall("s4 tag", 0, 32'd0, 1, 32'h8100_000A);
        push("s4 runt", 0, 0, 3'd0, 32'd0, 1, 0, 12'd0, 1, 0, 0, 3'd0, 32'd0, 0, 1);
        idle("s4 after");

        // in_drop at word 6, new frame two cycles later.
        strt("s5 start", 12'h0C8, 0);
        for (int i = 0; i < 3; i++) fwd("s5 hdr", W(5, i), 0);
        stall("s5 tag", 1, W(5, 3), 0, 32'h8100_00C8);
        for (int i = 3; i < 6; i++) fwd("s5 body", W(5, i), 0);
        push("s5 drop", 0, 1, 3'd4, W(5, 6), 0, 1, 12'd0, 1, 0, 0, 3'd0, 32'd0, 0, 1);
        idle("s5 gap");
        strt("s5b start", 12'h0C9, 0);
        for (int i = 0; i < 3; i++) fwd("s5b hdr", W(6, i), 0);
        stall("s5b tag", 1, W(6, 3), 1, 32'h8100_00C9);
        fwd("s5b last", W(6, 3), 1);
        idle("s5b after");

        // Restart at word 8 of an open frame; new VID at the top of the range.
        strt("s6 start", 12'h0D0, 0);
        for (int i = 0; i < 3; i++) fwd("s6 hdr", W(10, i), 0);
        stall("s6 tag", 1, W(10, 3), 0, 32'h8100_00D0);
        for (int i = 3; i < 8; i++) fwd("s6 body", W(10, i), 0);
        strt("s6 restart", 12'hFFF, 1);
        for (int i = 0; i < 3; i++) fwd("s6b hdr", W(7, i), 0);
        stall("s6b tag", 1, W(7, 3), 0, 32'h8100_0FFF);
        fwd("s6b last", W(7, 3), 1);
        idle("s6b after");

        // Short word 2 discards the rest of the frame.
        strt("s7 start", 12'h020, 0);
        fwd("s7 w0", W(9, 0), 0);
        fwd("s7 w1", W(9, 1), 0);
        push("s7 short w2", 0, 1, 3'd2, W(9, 2), 0, 0, 12'd0, 1, 0, 0, 3'd0, 32'd0, 0, 1);
        push("s7 discard", 0, 1, 3'd4, W(9, 3), 1, 0, 12'd0, 1, 0, 0, 3'd0, 32'd0, 0, 0);
        idle("s7 after");

        // Reset state.
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk_quiet("reset state");
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            tag_enable      = tbl[i].te;
            native_untagged = tbl[i].nu;
            port_vlan       = tbl[i].pv;
            in_start        = tbl[i].st;
            in_data_valid   = tbl[i].dv;
            in_bytes_valid  = tbl[i].bv;
            in_data         = tbl[i].d;
            in_commit       = tbl[i].cm;
            in_drop         = tbl[i].dr;
            in_frame_vlan   = tbl[i].fv;
            #1;
            chk({tbl[i].nm, " in_ready"}, 64'(in_ready), 64'(tbl[i].rdy));
            @(posedge clk);
            @(negedge clk);
            chk({tbl[i].nm, " ctrl"}, 64'({out_start, out_data_valid, out_commit, out_drop}),
                64'({tbl[i].ost, tbl[i].odv, tbl[i].ocm, tbl[i].odr}));
            if (tbl[i].odv)
                chk({tbl[i].nm, " data"}, 64'({out_bytes_valid, out_data}),
                    64'({tbl[i].obv, tbl[i].od}));
        end

        // Reset in the middle of a frame: everything clears at once, no drop afterwards.
        tag_enable = 1'b1; native_untagged = 1'b0; port_vlan = 12'd1;
        in_start = 1'b1; in_frame_vlan = 12'h0E0;
        in_data_valid = 1'b0; in_commit = 1'b0; in_drop = 1'b0;
        @(negedge clk);
        in_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_data_valid = 1'b1; in_bytes_valid = 3'd4; in_data = W(11, i);
            @(negedge clk);
        end
        chk("midframe word1", 64'({out_data_valid, out_data}), 64'({1'b1, W(11, 1)}));
        in_data_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk_quiet("midframe reset async");
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk_quiet("midframe reset held");
        end
        rst = 1'b0;
        @(negedge clk);
        chk_quiet("after reset release");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
